peripheral_bb_wb_mem: RTL and testbench
=======================================

Name: peripheral_bb_wb_mem

Overview:
Parametrised Wishbone B3 slave memory model for bus-functional testbenches; successor to the fixed 32-bit BFM constants.
- Generalised in address/data width, depth and wait states.
- Adds byte-lane writes and registered-feedback incrementing bursts (linear, wrap-4/8/16).
- Sits on the slave side of any Wishbone master (DMA engine, CPU BFM) in block and SoC benches.

Parameters:
AW, 32, address bus width in bits
DW, 32, data bus width in bits; power of two, at least 8
MEM_WORDS, 1024, depth in DW-bit words; power of two
WAIT_STATES, 0, extra cycles before the first ack of each access (0..15)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
adr_i  in  AW  byte address
dat_i  in  DW  write data
sel_i  in  DW/8  byte lane selects
we_i  in  1  write enable
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe
cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
dat_o  out  DW  read data
ack_o  out  1  normal termination
err_o  out  1  error termination

Behaviour:
- Reset: asynchronous assert forces state to IDLE, wait counter to 0 and burst address to 0. Outputs reset to ack_o=0, err_o=0, dat_o=0. Memory contents are not reset.
- Word index is adr[AW-1:log2(DW/8)] modulo MEM_WORDS. Out-of-range addresses alias.
- States:
  - IDLE: on cyc_i&stb_i, latch the address and load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: decrement the counter each cycle; at 0, go to ACK.
  - ACK: ack_o=1 for exactly one cycle, registered.
    - Write: enabled lanes of dat_i are stored on that edge; sel_i=0 lanes are unchanged.
    - Read: dat_o carries mem[index] in the same cycle as ack_o; it holds its value otherwise.
    - If cti_i=010, go to BURST and advance the address. Otherwise go to IDLE.
  - BURST: one ack per cycle while stb_i=1, with no wait states after the first beat.
    - The address advances per bte_i. Wrap-N wraps within an N-word aligned block, so the low log2(N) index bits increment modulo N.
    - stb_i=0: ack_o=0, the address holds and the state stays BURST.
    - An ack issued with cti_i=111 is the last beat; go to IDLE.
- Classic cycles: ack_o never asserts on two consecutive cycles. After IDLE there is at least one cycle gap.
- cyc_i=0 in any state: go to IDLE next cycle, no ack issued, any pending write is discarded.
- err_o is never asserted unless the optional feature is enabled.
- ack_o and err_o are mutually exclusive.
- First-beat latency: ack_o rises WAIT_STATES+1 cycles after cyc_i&stb_i is first sampled high.

Optional Feature:
Macro PERIPHERAL_BB_WB_MEM_ERR_EN.
- Defined: any beat whose un-modded word index is >= MEM_WORDS terminates with err_o=1 instead of ack_o. It writes nothing and drives dat_o=0. In a burst it ends the burst and returns to IDLE.
- Undefined: addresses alias and err_o is tied to 0.

Decomposition:
- Package peripheral_bb_pkg gains:
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - BTE constants: BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16.
  - A state enum typedef.
  - The existing AW/DW are kept as package defaults.
- One sub-module, peripheral_bb_wb_addr_gen: combinational next-address from current index and bte_i, reused by master BFMs.

Test Plan:
- Classic write adr=0x10, dat=0xDEADBEEF, sel=1111, WAIT_STATES=0, then classic read of 0x10 -> ack 1 cycle after stb each time; read returns 0xDEADBEEF.
- Byte lanes: write 0xFFFFFFFF to 0x20, then write 0x00000000 with sel=0101, read back -> 0xFF00FF00.
- WAIT_STATES=3, classic read -> ack_o rises exactly 4 cycles after stb sampled; 1-cycle pulse; no back-to-back ack.
- Wrap4 read burst from 0x38 (index 14), 4 beats, last with cti=111 -> indices 14,15,12,13; acks on 4 consecutive cycles, then IDLE.
- Linear write burst of 3 beats with stb_i dropped for 2 cycles after beat 1 -> ack low during the gap, address held, total 3 acks, indices contiguous.
- ERR_EN defined, MEM_WORDS=1024, read at 0x1000 -> err_o=1, ack_o=0, dat_o=0. Mid-burst rst_i pulse -> ack_o/err_o=0 immediately, state IDLE.

Source files
------------

// File: rtl/peripheral_bb_pkg.sv
// Shared Wishbone BFM definitions: default bus widths, cycle/burst type codes
// and the slave state encoding used by peripheral_bb_wb_mem and its helpers.
package peripheral_bb_pkg;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_BURST = 2'd3
    } wb_state_e;

    // Wait-state preload; values above 15 saturate rather than wrap.
    function automatic logic [3:0] wait_load(input int ws);
        if (ws > 15) begin
            return 4'd15;
        end
        return 4'(ws);
    endfunction

endpackage

// File: rtl/peripheral_bb_wb_addr_gen.sv
// Next word index for a Wishbone incrementing burst: linear, or wrapping within
// an aligned 4/8/16-word block. Purely combinational so master BFMs can share it.
module peripheral_bb_wb_addr_gen
    import peripheral_bb_pkg::*;
#(
    parameter int XW = 30
) (
    input  logic [XW-1:0] idx_i,
    input  logic [1:0]    bte_i,
    output logic [XW-1:0] nxt_o
);

    logic [XW-1:0] wrap_mask;
    logic [XW-1:0] idx_inc;

    // Bits inside the mask count up; bits outside it keep the block base fixed.
    always_comb begin
        case (bte_i)
            BTE_WRAP4:  wrap_mask = XW'(3);
            BTE_WRAP8:  wrap_mask = XW'(7);
            BTE_WRAP16: wrap_mask = XW'(15);
            default:    wrap_mask = '1;
        endcase
        idx_inc = idx_i + XW'(1);
        nxt_o   = (idx_i & ~wrap_mask) | (idx_inc & wrap_mask);
    end

endmodule

// File: rtl/peripheral_bb_wb_mem.sv
// Parametrised Wishbone B3 slave memory with wait states, byte lanes and
// registered-feedback bursts. Define PERIPHERAL_BB_WB_MEM_ERR_EN to error-terminate out-of-range beats.
module peripheral_bb_wb_mem
    import peripheral_bb_pkg::*;
#(
    parameter int AW          = DEFAULT_AW,
    parameter int DW          = DEFAULT_DW,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   adr_i,
    input  logic [DW-1:0]   dat_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic            we_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic [2:0]      cti_i,
    input  logic [1:0]      bte_i,
    output logic [DW-1:0]   dat_o,
    output logic            ack_o,
    output logic            err_o
);

    localparam int NB = DW / 8;
    localparam int OB = (NB > 1) ? $clog2(NB) : 0;
    localparam int XW = AW - OB;
    localparam int IW = $clog2(MEM_WORDS);

    wb_state_e       state_q, state_d;
    logic [XW-1:0]   addr_q, addr_d;
    logic [XW-1:0]   addr_nxt;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW-1:0]   rd_q;
    logic [DW-1:0]   mem_q [MEM_WORDS];

    logic            beat;
    logic            addr_oor;
    logic            mem_we;
    logic            rd_beat;
    logic            unused_ok;

    assign unused_ok = ^adr_i;

    peripheral_bb_wb_addr_gen #(
        .XW (XW)
    ) u_addr_gen (
        .idx_i (addr_q),
        .bte_i (bte_i),
        .nxt_o (addr_nxt)
    );

`ifdef PERIPHERAL_BB_WB_MEM_ERR_EN
    generate
        if (XW > IW) begin : g_oor_chk
            assign addr_oor = |addr_q[XW-1:IW];
        end else begin : g_oor_none
            assign addr_oor = 1'b0;
        end
    endgenerate
`else
    assign addr_oor = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
        end
    end

    // Contents are never reset. The read port prefetches the index of the next
    // cycle, so the data is already registered when that cycle's ack comes up.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_i[b]) begin
                    mem_q[addr_q[IW-1:0]][b*8 +: 8] <= dat_i[b*8 +: 8];
                end
            end
        end
        rd_q <= mem_q[addr_d[IW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    addr_d  = adr_i[AW-1:OB];
                    cnt_d   = wait_load(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK, ST_BURST: begin
                if (beat) begin
                    if (!addr_oor && cti_i == CTI_INCR) begin
                        state_d = ST_BURST;
                        addr_d  = addr_nxt;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Dropping cyc_i abandons the access from any state.
        if (!cyc_i) begin
            state_d = ST_IDLE;
        end
        if (rd_beat) begin
            dat_d = rd_q;
        end else if (beat && addr_oor) begin
            dat_d = '0;
        end
    end

    always_comb begin
        beat    = cyc_i && ((state_q == ST_ACK) || (state_q == ST_BURST && stb_i));
        ack_o   = beat && !addr_oor;
        err_o   = beat && addr_oor;
        mem_we  = ack_o && we_i;
        rd_beat = ack_o && !we_i;
        dat_o   = dat_q;
        if (rd_beat) begin
            dat_o = rd_q;
        end else if (err_o) begin
            dat_o = '0;
        end
    end

endmodule

// File: tb/tb_peripheral_bb_wb_mem.sv
// Self-checking bench for peripheral_bb_wb_mem: two instances (0 and 3 wait
// states) driven by a shared bus, checked against an array-based memory model.
module tb_peripheral_bb_wb_mem;
    import peripheral_bb_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MEM_WORDS = 1024;
`ifdef PERIPHERAL_BB_WB_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat_w = '0;
    logic [3:0]    sel = '0;
    logic          we = 1'b0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic [2:0]    cti = CTI_CLASSIC;
    logic [1:0]    bte = BTE_LINEAR;
    bit            dut_sel = 1'b0;

    logic          cyc0, cyc1;
    logic [DW-1:0] dat_r0, dat_r1, dat_r;
    logic          ack0, ack1, ack;
    logic          err0, err1, err;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [2][MEM_WORDS];

    always #5 clk = ~clk;

    assign cyc0  = cyc && (dut_sel == 1'b0);
    assign cyc1  = cyc && (dut_sel == 1'b1);
    assign ack   = dut_sel ? ack1 : ack0;
    assign err   = dut_sel ? err1 : err0;
    assign dat_r = dut_sel ? dat_r1 : dat_r0;

    peripheral_bb_wb_mem #(
        .AW (AW), .DW (DW), .MEM_WORDS (MEM_WORDS), .WAIT_STATES (0)
    ) dut0 (
        .clk_i (clk), .rst_i (rst), .adr_i (adr), .dat_i (dat_w), .sel_i (sel),
        .we_i (we), .cyc_i (cyc0), .stb_i (stb), .cti_i (cti), .bte_i (bte),
        .dat_o (dat_r0), .ack_o (ack0), .err_o (err0)
    );

    peripheral_bb_wb_mem #(
        .AW (AW), .DW (DW), .MEM_WORDS (MEM_WORDS), .WAIT_STATES (3)
    ) dut3 (
        .clk_i (clk), .rst_i (rst), .adr_i (adr), .dat_i (dat_w), .sel_i (sel),
        .we_i (we), .cyc_i (cyc1), .stb_i (stb), .cti_i (cti), .bte_i (bte),
        .dat_o (dat_r1), .ack_o (ack1), .err_o (err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (dut%0d t=%0t)", tag, got, exp, dut_sel, $time);
        end
    endtask

    function automatic bit model_oor(input int i);
        return ERR_EN && (i >= MEM_WORDS);
    endfunction

    function automatic int next_idx(input int i, input logic [1:0] b);
        int n;
        case (b)
            BTE_WRAP4:  n = 4;
            BTE_WRAP8:  n = 8;
            BTE_WRAP16: n = 16;
            default:    return i + 1;
        endcase
        return (i / n) * n + ((i % n) + 1) % n;
    endfunction

    task automatic model_write(input int i, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[dut_sel][i % MEM_WORDS][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic classic(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdata);
        int n, idx, lat;
        bit exp_err, done;
        logic [31:0] exp_rd;
        idx     = int'(a >> 2);
        exp_err = model_oor(idx);
        exp_rd  = exp_err ? 32'h0 : model_mem[dut_sel][idx % MEM_WORDS];
        lat     = dut_sel ? 4 : 1;
        @(negedge clk);
        adr = a; dat_w = d; sel = s; we = w; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        cyc = 1'b1; stb = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            #1;
            if (ack || err) begin
                done = 1'b1;
            end else if (n >= 40) begin
                chk("classic_timeout", {31'b0, ack | err}, 32'd1);
                done = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        rdata = dat_r;
        chk("classic_latency", n, lat);
        chk("classic_err", {31'b0, err}, {31'b0, exp_err});
        chk("classic_ack", {31'b0, ack}, {31'b0, !exp_err});
        if (!w) chk("classic_rdata", dat_r, exp_rd);
        if (w && !exp_err) model_write(idx, d, s);
        $display("%s dut%0d adr=%h dat=%h sel=%b lat=%0d err=%0b",
                 w ? "wr" : "rd", dut_sel, a, w ? d : rdata, s, n, err);
        @(negedge clk);
        #1;
        chk("classic_gap", {31'b0, ack | err}, 32'd0);
        if (!w) chk("classic_hold", dat_r, exp_rd);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic drive_beat(input bit w, input int idx, input logic [1:0] b,
                              input bit last, input bit rnd_sel);
        adr   = 32'(idx) << 2;
        dat_w = $urandom;
        sel   = rnd_sel ? 4'($urandom_range(0, 15)) : 4'hF;
        we    = w;
        bte   = b;
        cti   = last ? CTI_EOB : CTI_INCR;
    endtask

    task automatic run_burst(input bit w, input int start_idx, input logic [1:0] b,
                             input int nbeats, input int gap_after, input int gap_len,
                             input bit rnd_sel, input bit check_consec);
        int idx, beat, idle_cnt, cyc_cnt, first_cyc, last_cyc;
        bit exp_err, ended;
        idx = start_idx; beat = 0; idle_cnt = 0; cyc_cnt = 0;
        first_cyc = 0; last_cyc = 0; ended = 1'b0;
        @(negedge clk);
        drive_beat(w, idx, b, nbeats == 1, rnd_sel);
        cyc = 1'b1; stb = 1'b1;
        while (!ended && idle_cnt < 100) begin
            #1;
            if (ack || err) begin
                exp_err = model_oor(idx);
                chk("burst_err", {31'b0, err}, {31'b0, exp_err});
                if (!w) chk("burst_rdata", dat_r, exp_err ? 32'h0 : model_mem[dut_sel][idx % MEM_WORDS]);
                else if (!exp_err) model_write(idx, dat_w, sel);
                if (beat == 0) first_cyc = cyc_cnt;
                last_cyc = cyc_cnt;
                beat++;
                idx   = next_idx(idx, b);
                ended = exp_err || (beat == nbeats);
                @(negedge clk);
                cyc_cnt++;
                if (!ended && beat == gap_after) begin
                    stb = 1'b0;
                    for (int g = 0; g < gap_len; g++) begin
                        #1;
                        chk("burst_gap", {31'b0, ack | err}, 32'd0);
                        @(negedge clk);
                        cyc_cnt++;
                    end
                    stb = 1'b1;
                end
                if (!ended) drive_beat(w, idx, b, beat == nbeats - 1, rnd_sel);
            end else begin
                @(negedge clk);
                cyc_cnt++;
                idle_cnt++;
            end
        end
        chk("burst_beats", beat, nbeats);
        if (check_consec) chk("burst_consec", last_cyc - first_cyc, nbeats - 1);
        cti = CTI_CLASSIC;
        #1;
        chk("burst_idle", {31'b0, ack | err}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        $display("burst dut%0d %s start=%0d bte=%0d beats=%0d gap_after=%0d gap_len=%0d",
                 dut_sel, w ? "wr" : "rd", start_idx, b, beat, gap_after, gap_len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack0", {31'b0, ack0}, 32'd0);
        chk("rst_err0", {31'b0, err0}, 32'd0);
        chk("rst_dat0", dat_r0, 32'd0);
        chk("rst_ack3", {31'b0, ack1}, 32'd0);
        chk("rst_err3", {31'b0, err1}, 32'd0);
        chk("rst_dat3", dat_r1, 32'd0);
        rst = 1'b0;

        // Fill both memories so every later read has a defined expectation.
        for (int k = 0; k < 2; k++) begin
            dut_sel = k[0];
            run_burst(1'b1, 0, BTE_LINEAR, MEM_WORDS, 0, 0, 1'b0, 1'b1);
        end

        dut_sel = 1'b0;
        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        classic(1'b0, 32'h10, 32'h0, 4'hF, rd);
        chk("plan_deadbeef", rd, 32'hDEADBEEF);
        classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rd);
        classic(1'b1, 32'h20, 32'h00000000, 4'b0101, rd);
        classic(1'b0, 32'h20, 32'h0, 4'hF, rd);
        chk("plan_lanes", rd, 32'hFF00FF00);

        dut_sel = 1'b1;
        classic(1'b1, 32'h10, 32'h12345678, 4'hF, rd);
        classic(1'b0, 32'h10, 32'h0, 4'hF, rd);
        chk("plan_ws3", rd, 32'h12345678);
        run_burst(1'b0, 14, BTE_WRAP4, 4, 0, 0, 1'b0, 1'b1);

        dut_sel = 1'b0;
        run_burst(1'b0, 14, BTE_WRAP4, 4, 0, 0, 1'b0, 1'b1);
        run_burst(1'b1, 40, BTE_LINEAR, 3, 1, 2, 1'b0, 1'b0);
        for (int i = 40; i < 43; i++) classic(1'b0, 32'(i) << 2, 32'h0, 4'hF, rd);
        classic(1'b0, 32'h1000, 32'h0, 4'hF, rd);
        classic(1'b1, 32'h1008, 32'hA5A5C3C3, 4'hF, rd);
        classic(1'b0, 32'h8, 32'h0, 4'hF, rd);

        // Reset pulse in the middle of a read burst.
        @(negedge clk);
        drive_beat(1'b0, 64, BTE_LINEAR, 1'b0, 1'b0);
        cyc = 1'b1; stb = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            #1;
            if (ack) n++;
            @(negedge clk);
        end
        chk("mid_rst_beats", n, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", {31'b0, ack0}, 32'd0);
        chk("mid_rst_err", {31'b0, err0}, 32'd0);
        chk("mid_rst_dat", dat_r0, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("rst dut0 mid-burst after %0d beats", n);
        classic(1'b0, 32'h100, 32'h0, 4'hF, rd);

        for (int t = 0; t < 150; t++) begin
            int op, len, gap_after;
            dut_sel = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 3);
            if (op == 0) begin
                classic(1'b0, 32'($urandom_range(0, 4 * MEM_WORDS - 1)) * 4 + 32'($urandom_range(0, 3)),
                        32'h0, 4'hF, rd);
            end else if (op == 1) begin
                classic(1'b1, 32'($urandom_range(0, 4 * MEM_WORDS - 1)) * 4 + 32'($urandom_range(0, 3)),
                        $urandom, 4'($urandom_range(0, 15)), rd);
            end else begin
                len       = $urandom_range(1, 8);
                gap_after = $urandom_range(0, len);
                run_burst(1'($urandom_range(0, 1)), $urandom_range(0, MEM_WORDS - 17),
                          2'($urandom_range(0, 3)), len, gap_after, $urandom_range(1, 3),
                          1'b1, (gap_after == 0) || (gap_after >= len));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
